tile_map_controller: RTL
========================

Name: tile_map_controller

Overview:
- Owns the 11x17 Bomberman play-field grid of 2-bit tile codes: 0 = empty, 1 = pillar, 2 = brick, 3 = bomb.
- Sequences a level load that writes pillars plus LFSR-placed bricks, one cell per clock.
- Arbitrates cell updates between the bomb-placement and explosion requesters using round-robin.
- Supplies a registered tile-code read port to the tile-matrix bitmap drawers.

Parameters:
- ROWS, 11, grid rows.
- COLS, 17, grid columns.
- DEFAULT_SEED, 8'hA5, LFSR seed used when seed input is 0.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startLevel  in  1  one-cycle pulse; begins level load
- seed  in  8  LFSR seed, sampled on startLevel
- loadBusy  out  1  high while in LOAD
- loadDone  out  1  one-cycle pulse after the last cell is written
- reqBomb  in  1  bomb placement request, held until grant
- bombRow  in  4  bomb target row
- bombCol  in  5  bomb target column
- gntBomb  out  1  one-cycle grant pulse; operation complete
- placeOk  out  1  valid with gntBomb; 1 = bomb written
- reqBlast  in  1  explosion clear request, held until grant
- blastRow  in  4  explosion target row
- blastCol  in  5  explosion target column
- gntBlast  out  1  one-cycle grant pulse
- blastPrev  out  2  valid with gntBlast; tile code before the clear
- drawRow  in  4  draw-port row
- drawCol  in  5  draw-port column
- drawCode  out  2  registered tile code for (drawRow, drawCol)

Behaviour:
Reset (resetN low, asynchronous):
- Grid loads the pillar pattern: cell = 1 where row and column are both even, else 0.
- State = IDLE; all outputs 0; round-robin pointer favours bomb; LFSR = DEFAULT_SEED.

States:
- IDLE: serve requests.
- LOAD: scan the grid.
- ACK: gap cycle after a grant.

startLevel:
- Sampled in any state; it has the highest priority.
- Next state is LOAD with cell index 0 (row-major).
- LFSR := seed, or DEFAULT_SEED if seed == 0.
- A pending request is not granted. A grant already registered still pulses.
- startLevel during LOAD restarts the load from cell 0.

LOAD:
- One cell per cycle, 187 cycles total.
- Pillar cell → 1.
- Else if cell is (0,0), (0,1) or (1,0) → 0 (player spawn corner).
- Else → 2 if LFSR[0] == 1, otherwise 0.
- LFSR (Fibonacci, taps x^8+x^6+x^5+x^4+1) advances every LOAD cycle, including pillar and spawn cells.
- loadBusy is high for the whole of LOAD.
- After cell (10,16): state → IDLE; loadDone pulses for 1 cycle on the transition; requests are not granted during LOAD.

IDLE arbitration:
- If exactly one request is high, that requester wins.
- If both are high, the requester the pointer favours wins; the pointer then flips to the other requester.
- The read-modify-write happens in the same cycle as the arbitration decision.
- The grant, placeOk and blastPrev outputs register at the next edge (1-cycle latency). State → ACK.

Bomb operation:
- If the coordinate is in range and the cell is 0: write 3, placeOk = 1.
- Otherwise: no write, placeOk = 0.

Blast operation:
- blastPrev = old code; out of range reports 0.
- If the old code is 2 or 3: write 0.
- Pillars and empty cells are unchanged.

ACK:
- Grant outputs fall to 0. No new grant is issued. Next state is IDLE.
- Requesters drop req in the cycle after the grant; a still-high req in IDLE is treated as a new request.

Draw port:
- drawCode <= grid[drawRow][drawCol] every cycle (1-cycle latency), in every state.
- Out-of-range coordinate → 0.
- In the cycle a write occurs, the draw port returns the pre-write value.

Widths:
- Range checks: row < ROWS, col < COLS.
- Cell index counter is 8 bits, wrapping to 0 at load end.

Test Plan:
- Reset, then draw (2,4), (3,4), (0,0) → drawCode = 1, 0, 1 one cycle after each address.
- startLevel with seed = 0 → loadBusy high for exactly 187 cycles, then loadDone pulses once; (0,1) and (1,0) read 0; all even/even cells read 1; brick pattern matches a golden LFSR model seeded with 8'hA5.
- Bomb request at (1,1) on an empty cell → gntBomb pulse 1 cycle later with placeOk = 1 and (1,1) reads 3; repeat the same request → placeOk = 0.
- reqBomb and reqBlast both held from reset → grants alternate bomb, blast, bomb…, with one ACK gap cycle between successive grants and never two grants in the same cycle.
- Blast at (2,2) (pillar) → blastPrev = 1, cell stays 1; blast at a brick → blastPrev = 2, cell reads 0; blast at (11,0) → blastPrev = 0, no write.
- Assert startLevel mid-LOAD at cell 90 and with reqBlast pending → load restarts at cell 0, full 187 cycles, no gntBlast until after loadDone; resetN low mid-LOAD → immediate pillar-only grid, loadBusy = 0.

Source files
------------

// File: rtl/tile_map_controller_if.sv
// rtl/tile_map_controller_if.sv - level-load, requester and draw-port signals of the tile map controller
interface tile_map_controller_if;
  logic       startLevel;
  logic [7:0] seed;
  logic       loadBusy;
  logic       loadDone;
  logic       reqBomb;
  logic [3:0] bombRow;
  logic [4:0] bombCol;
  logic       gntBomb;
  logic       placeOk;
  logic       reqBlast;
  logic [3:0] blastRow;
  logic [4:0] blastCol;
  logic       gntBlast;
  logic [1:0] blastPrev;
  logic [3:0] drawRow;
  logic [4:0] drawCol;
  logic [1:0] drawCode;

  modport master (
    output startLevel, seed, reqBomb, bombRow, bombCol,
           reqBlast, blastRow, blastCol, drawRow, drawCol,
    input  loadBusy, loadDone, gntBomb, placeOk, gntBlast, blastPrev, drawCode
  );

  modport slave (
    input  startLevel, seed, reqBomb, bombRow, bombCol,
           reqBlast, blastRow, blastCol, drawRow, drawCol,
    output loadBusy, loadDone, gntBomb, placeOk, gntBlast, blastPrev, drawCode
  );
endinterface

// File: rtl/tile_map_controller.sv
// rtl/tile_map_controller.sv - Bomberman tile grid: LFSR level load, round-robin bomb/blast updates, draw port
module tile_map_controller #(
  parameter int         ROWS         = 11,
  parameter int         COLS         = 17,
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               resetN,
  tile_map_controller_if.slave bus
);
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       ptr_q, ptr_d;
  logic       load_busy_q, load_busy_d;
  logic       load_done_q, load_done_d;
  logic       gnt_bomb_q, gnt_bomb_d;
  logic       place_ok_q, place_ok_d;
  logic       gnt_blast_q, gnt_blast_d;
  logic [1:0] blast_prev_q, blast_prev_d;
  logic [1:0] draw_code_q, draw_code_d;
  logic [1:0] grid_q [CELLS];

  logic       wr_en;
  logic [7:0] wr_idx;
  logic [1:0] wr_data;
  logic       grant_bomb, grant_blast;
  logic [7:0] bomb_idx, blast_idx, draw_idx;
  logic       bomb_ok, blast_ok, draw_ok;
  logic [1:0] blast_old;

  function automatic logic in_range(input logic [3:0] r, input logic [4:0] c);
    return (int'(r) < ROWS) && (int'(c) < COLS);
  endfunction

  function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [4:0] c);
    return 8'(r) * 8'(COLS) + 8'(c);
  endfunction

  assign bomb_idx  = cell_idx(bus.bombRow, bus.bombCol);
  assign blast_idx = cell_idx(bus.blastRow, bus.blastCol);
  assign draw_idx  = cell_idx(bus.drawRow, bus.drawCol);
  assign bomb_ok   = in_range(bus.bombRow, bus.bombCol);
  assign blast_ok  = in_range(bus.blastRow, bus.blastCol);
  assign draw_ok   = in_range(bus.drawRow, bus.drawCol);
  assign blast_old = blast_ok ? grid_q[blast_idx] : 2'd0;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    lfsr_d       = lfsr_q;
    ptr_d        = ptr_q;
    load_done_d  = 1'b0;
    gnt_bomb_d   = 1'b0;
    place_ok_d   = 1'b0;
    gnt_blast_d  = 1'b0;
    blast_prev_d = 2'd0;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_data      = 2'd0;
    grant_bomb   = 1'b0;
    grant_blast  = 1'b0;
    // Reads see grid_q, so a same-cycle write is not visible until the next read.
    draw_code_d  = draw_ok ? grid_q[draw_idx] : 2'd0;

    if (bus.startLevel) begin
      state_d = LOAD;
      idx_d   = 8'd0;
      row_d   = 4'd0;
      col_d   = 5'd0;
      lfsr_d  = (bus.seed == 8'd0) ? DEFAULT_SEED : bus.seed;
    end else begin
      case (state_q)
        LOAD: begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
          if (!row_q[0] && !col_q[0]) begin
            wr_data = 2'd1;
          end else if ((row_q == 4'd0 && col_q < 5'd2) || (row_q == 4'd1 && col_q == 5'd0)) begin
            wr_data = 2'd0;
          end else begin
            wr_data = lfsr_q[0] ? 2'd2 : 2'd0;
          end
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          if (idx_q == 8'(CELLS - 1)) begin
            state_d     = IDLE;
            idx_d       = 8'd0;
            row_d       = 4'd0;
            col_d       = 5'd0;
            load_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
            if (col_q == 5'(COLS - 1)) begin
              col_d = 5'd0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
        ACK: state_d = IDLE;
        default: begin
          // The pointer only moves on contention, so a lone requester never steals the next tie.
          if (bus.reqBomb && bus.reqBlast) begin
            grant_bomb  = !ptr_q;
            grant_blast = ptr_q;
            ptr_d       = !ptr_q;
          end else begin
            grant_bomb  = bus.reqBomb;
            grant_blast = bus.reqBlast;
          end
          if (grant_bomb) begin
            state_d    = ACK;
            gnt_bomb_d = 1'b1;
            if (bomb_ok && grid_q[bomb_idx] == 2'd0) begin
              wr_en      = 1'b1;
              wr_idx     = bomb_idx;
              wr_data    = 2'd3;
              place_ok_d = 1'b1;
            end
          end else if (grant_blast) begin
            state_d      = ACK;
            gnt_blast_d  = 1'b1;
            blast_prev_d = blast_old;
            if (blast_old[1]) begin
              wr_en   = 1'b1;
              wr_idx  = blast_idx;
              wr_data = 2'd0;
            end
          end
        end
      endcase
    end

    load_busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      row_q        <= 4'd0;
      col_q        <= 5'd0;
      lfsr_q       <= DEFAULT_SEED;
      ptr_q        <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      gnt_bomb_q   <= 1'b0;
      place_ok_q   <= 1'b0;
      gnt_blast_q  <= 1'b0;
      blast_prev_q <= 2'd0;
      draw_code_q  <= 2'd0;
      for (int i = 0; i < CELLS; i++) begin
        grid_q[i] <= (((i / COLS) % 2) == 0 && ((i % COLS) % 2) == 0) ? 2'd1 : 2'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      lfsr_q       <= lfsr_d;
      ptr_q        <= ptr_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
      gnt_bomb_q   <= gnt_bomb_d;
      place_ok_q   <= place_ok_d;
      gnt_blast_q  <= gnt_blast_d;
      blast_prev_q <= blast_prev_d;
      draw_code_q  <= draw_code_d;
      if (wr_en) begin
        grid_q[wr_idx] <= wr_data;
      end
    end
  end

  assign bus.loadBusy  = load_busy_q;
  assign bus.loadDone  = load_done_q;
  assign bus.gntBomb   = gnt_bomb_q;
  assign bus.placeOk   = place_ok_q;
  assign bus.gntBlast  = gnt_blast_q;
  assign bus.blastPrev = blast_prev_q;
  assign bus.drawCode  = draw_code_q;
endmodule
